rec_play_seq: RTL
=================

Name: rec_play_seq

Overview:
- Controller that sequences the sound driver's shared single-port sample RAM between the record path (PDM decimator output) and the playback path (PWM player input).
- Detects record/playback button edges and runs the record/playback state machine.
- Generates RAM address, enable and write strobes, tracks the recorded length, and gates the mic clock and audio PWM enable.
- Sits between the button inputs, the PDM/PWM front-ends and the sample BRAM inside sounddriver.

Parameters:
ADDR_W, 14, RAM address width; depth = 2^ADDR_W samples
SAMPLE_W, 8, sample width in bits

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  synchronous, active-high reset
recordBtnEN  in  1  record button level, already debounced
playbackBtnEN  in  1  playback button level, already debounced
rec_sample_valid  in  1  one-cycle strobe: new decimated sample present
rec_sample  in  SAMPLE_W  decimated sample
play_sample_req  in  1  one-cycle strobe: PWM player wants the next sample
play_sample  out  SAMPLE_W  sample to PWM player, registered
play_sample_valid  out  1  one-cycle strobe: play_sample updated
mem_en  out  1  RAM enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  SAMPLE_W  RAM write data
mem_rdata  in  SAMPLE_W  RAM read data, 1-cycle read latency
mic_en  out  1  enables the mic clock generator and decimator
aud_en  out  1  audio PWM enable
rec_len  out  ADDR_W+1  number of valid stored samples

Behaviour:
- Reset: clk and reset as decided (one clock; synchronous, active-high reset).
  - All outputs go to 0; state = IDLE; wr_ptr = rd_ptr = 0; rec_len = 0.
  - Reset mid-record or mid-playback aborts immediately and discards the recording (rec_len = 0).
- Edge detect: register each button; rec_edge / play_edge = level high AND previous level low. A held button yields exactly one edge.
- All RAM outputs (mem_en, mem_we, mem_addr, mem_wdata) are registered.
- States: IDLE, RECORD, PLAY_WAIT, PLAY_RD, PLAY_CAP.
- IDLE:
  - rec_edge -> RECORD; wr_ptr = 0; rec_len = 0.
  - else play_edge AND rec_len != 0 -> PLAY_WAIT; rd_ptr = 0.
  - play_edge with rec_len == 0 is ignored.
  - Both edges in the same cycle: record wins.
- RECORD:
  - mic_en = 1.
  - Each rec_sample_valid: next cycle mem_en = mem_we = 1, mem_addr = wr_ptr, mem_wdata = rec_sample; wr_ptr++ and rec_len++ on the same edge.
  - Exit to IDLE, mic_en = 0, when:
    - rec_edge occurs (stop), or
    - rec_len reaches 2^ADDR_W (full). The final write completes; later rec_sample_valid strobes are dropped.
  - rec_sample_valid coincident with the stop edge is still written.
  - play_edge is ignored.
- PLAY_WAIT:
  - aud_en = 1.
  - play_sample_req -> PLAY_RD.
  - play_edge -> IDLE (abort), aud_en = 0.
  - rd_ptr == rec_len -> IDLE (end of playback, single pass).
  - rec_edge is ignored.
- Read latency: req sampled at edge E0.
  - PLAY_RD: mem_en = 1, mem_we = 0, mem_addr = rd_ptr during the cycle after E0.
  - RAM samples at E1 -> PLAY_CAP.
  - At E2 play_sample <= mem_rdata; rd_ptr++; play_sample_valid high for exactly one cycle after E2; -> PLAY_WAIT.
  - Fixed request-to-valid latency: 2 edges.
- play_sample_req during PLAY_RD or PLAY_CAP is ignored (the player must not request faster than every 3 cycles).
- play_sample holds its last value outside a capture.
- mem_we is never 1 outside RECORD. mem_en is 0 in IDLE.
- Pointer arithmetic: wr_ptr/rd_ptr are ADDR_W-bit, wrapping modulo 2^ADDR_W; rec_len is ADDR_W+1 bits so a full buffer is representable.

Optional Feature:
LOOP_PLAYBACK_EN
- Defined: when rd_ptr reaches rec_len in PLAY_WAIT, rd_ptr reloads to 0 and playback continues; only play_edge or reset returns to IDLE.
- Undefined: single pass; rd_ptr == rec_len -> IDLE with aud_en = 0.

Test Plan (ADDR_W = 4, SAMPLE_W = 8):
- Record 5 samples: reset, rec_edge, valids with 0x11..0x55, rec_edge -> RAM[0..4] = 0x11..0x55, rec_len = 5, mic_en high only in RECORD, mem_we exactly 5 pulses.
- Playback single pass: play_edge, then req every 10 cycles -> play_sample = 0x11,0x22,0x33,0x44,0x55, each valid 2 edges after its req; then IDLE, aud_en = 0; a 6th req gets no valid.
- Full buffer: 20 valids after rec_edge -> exactly 16 writes (addr 0..15), rec_len = 16, auto return to IDLE, mic_en = 0.
- Guards: play_edge with rec_len = 0 -> stays IDLE. rec_edge and play_edge in the same cycle -> RECORD. Button held 100 cycles -> one edge. play_edge during RECORD -> ignored.
- Abort and reset: play_edge after 2 samples played -> IDLE, rec_len still 5. Reset asserted in RECORD after 3 writes -> all outputs 0, rec_len = 0.
- LOOP_PLAYBACK_EN defined, rec_len = 3: 7 reqs -> samples at addresses 0,1,2,0,1,2,0; play_edge stops playback.

Source files
------------

// File: rtl/rec_play_seq.sv
// Record/playback sequencer for the shared single-port sample RAM.
// Define LOOP_PLAYBACK_EN to repeat playback until the play button is pressed again.
module rec_play_seq #(
  parameter int ADDR_W   = 14,
  parameter int SAMPLE_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                recordBtnEN,
  input  logic                playbackBtnEN,
  input  logic                rec_sample_valid,
  input  logic [SAMPLE_W-1:0] rec_sample,
  input  logic                play_sample_req,
  output logic [SAMPLE_W-1:0] play_sample,
  output logic                play_sample_valid,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [SAMPLE_W-1:0] mem_wdata,
  input  logic [SAMPLE_W-1:0] mem_rdata,
  output logic                mic_en,
  output logic                aud_en,
  output logic [ADDR_W:0]     rec_len
);

  // state       | meaning
  // S_IDLE      | waiting for a button edge
  // S_RECORD    | writing decimated samples to RAM
  // S_PLAY_WAIT | playback armed, waiting for player request
  // S_PLAY_RD   | RAM read issued
  // S_PLAY_CAP  | capturing RAM read data
  typedef enum logic [2:0] {
    S_IDLE, S_RECORD, S_PLAY_WAIT, S_PLAY_RD, S_PLAY_CAP
  } state_t;

  localparam logic [ADDR_W:0] LEN_LAST = {1'b0, {ADDR_W{1'b1}}};

  state_t              r_state, w_state_nxt;
  logic                r_rec_btn_q, r_play_btn_q;
  logic                w_rec_edge, w_play_edge;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W:0]     r_rd_cnt, r_rec_len, w_rd_cnt_inc;
  logic                w_rec_start, w_play_start, w_wr_fire, w_rd_fire, w_cap_fire;

  assign w_rec_edge   = recordBtnEN & ~r_rec_btn_q;
  assign w_play_edge  = playbackBtnEN & ~r_play_btn_q;
  assign w_rd_cnt_inc = r_rd_cnt + (ADDR_W+1)'(1);

  assign mic_en  = (r_state == S_RECORD);
  assign aud_en  = (r_state == S_PLAY_WAIT) || (r_state == S_PLAY_RD) || (r_state == S_PLAY_CAP);
  assign rec_len = r_rec_len;

  always_comb begin
    w_state_nxt  = r_state;
    w_rec_start  = 1'b0;
    w_play_start = 1'b0;
    w_wr_fire    = 1'b0;
    w_rd_fire    = 1'b0;
    w_cap_fire   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rec_edge) begin
          w_state_nxt = S_RECORD;
          w_rec_start = 1'b1;
        end else if (w_play_edge && (r_rec_len != '0)) begin
          w_state_nxt  = S_PLAY_WAIT;
          w_play_start = 1'b1;
        end
      end
      S_RECORD: begin
        w_wr_fire = rec_sample_valid;
        // The write that fills the buffer is issued on the same edge we leave.
        if (w_rec_edge || (w_wr_fire && (r_rec_len == LEN_LAST)))
          w_state_nxt = S_IDLE;
      end
      S_PLAY_WAIT: begin
        if (w_play_edge)
          w_state_nxt = S_IDLE;
`ifndef LOOP_PLAYBACK_EN
        else if (r_rd_cnt == r_rec_len)
          w_state_nxt = S_IDLE;
`endif
        else if (play_sample_req) begin
          w_state_nxt = S_PLAY_RD;
          w_rd_fire   = 1'b1;
        end
      end
      S_PLAY_RD:  w_state_nxt = S_PLAY_CAP;
      S_PLAY_CAP: begin
        w_state_nxt = S_PLAY_WAIT;
        w_cap_fire  = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state           <= S_IDLE;
      r_rec_btn_q       <= 1'b0;
      r_play_btn_q      <= 1'b0;
      r_wr_ptr          <= '0;
      r_rd_cnt          <= '0;
      r_rec_len         <= '0;
      mem_en            <= 1'b0;
      mem_we            <= 1'b0;
      mem_addr          <= '0;
      mem_wdata         <= '0;
      play_sample       <= '0;
      play_sample_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_rec_btn_q  <= recordBtnEN;
      r_play_btn_q <= playbackBtnEN;
      mem_en       <= w_wr_fire | w_rd_fire;
      mem_we       <= w_wr_fire;
      if (w_rec_start) begin
        r_wr_ptr  <= '0;
        r_rec_len <= '0;
      end
      if (w_wr_fire) begin
        mem_addr  <= r_wr_ptr;
        mem_wdata <= rec_sample;
        r_wr_ptr  <= r_wr_ptr + ADDR_W'(1);
        r_rec_len <= r_rec_len + (ADDR_W+1)'(1);
      end
      if (w_play_start)
        r_rd_cnt <= '0;
      // The read counter is one bit wider than the address so a full buffer ends cleanly.
      if (w_rd_fire)
        mem_addr <= r_rd_cnt[ADDR_W-1:0];
      play_sample_valid <= w_cap_fire;
      if (w_cap_fire) begin
        play_sample <= mem_rdata;
`ifdef LOOP_PLAYBACK_EN
        r_rd_cnt <= (w_rd_cnt_inc == r_rec_len) ? '0 : w_rd_cnt_inc;
`else
        r_rd_cnt <= w_rd_cnt_inc;
`endif
      end
    end
  end

endmodule
